bfx_control: RTL and testbench
==============================

// Module: bfx_control
// PURPOSE
//  Sequencer for the bfX core: fetches 8-bit instructions, classifies them through the
//  existing `decode` block, and executes each one. It owns the PC, the data pointer and
//  the bracket-depth counter, drives data-memory writes, and handshakes the byte I/O ports.
//  Sits between imem/dmem and the host harness; one instruction in flight at a time.
// PARAMETERS
//  PC_W     10  instruction address width; imem depth 2**PC_W
//  DPTR_W    8  data pointer width; dmem depth 2**DPTR_W, pointer wraps modulo 2**DPTR_W
//  DEPTH_W   6  bracket nesting counter width; max nesting depth 2**DEPTH_W-1
// PORTS
//  clk         in   1       clock, rising edge
//  rst_n       in   1       async active-low reset
//  start       in   1       begin execution at pc=0; sampled only in IDLE
//  imem_addr   out  PC_W    instruction address, registered
//  imem_rdata  in   8       instruction byte, valid the cycle after imem_addr changes (sync ROM)
//  dptr        out  DPTR_W  data pointer / dmem address
//  dmem_rdata  in   8       cell at dptr, combinational read
//  dmem_we     out  1       write strobe, one cycle
//  dmem_wdata  out  8       write data
//  in_ready    out  1       requesting an input byte
//  in_valid    in   1       input byte available; transfer when in_valid & in_ready
//  in_data     in   8       input byte
//  out_valid   out  1       output byte pending; transfer when out_valid & out_ready
//  out_ready   in   1       sink accepts
//  out_data    out  8       output byte (= dmem_rdata while out_valid)
//  busy        out  1       state not IDLE/HALT
//  halted      out  1       stop executed; sticky until reset
//  error       out  1       unmatched bracket or depth overflow; sticky until reset
// BEHAVIOUR
//  Reset: state=IDLE; pc, imem_addr, dptr, depth = 0; all strobes, busy, halted, error = 0.
//  Reset mid-operation aborts immediately: pending in_ready/out_valid drop with rst_n low.
//  Op classes (ix[3:1]; mode = ix[0]): 000 ptr (+1 if mode=0, -1 if mode=1); 001 data (same
//  rule); 010 io (mode 0 = input, 1 = output); 011 branch (mode 0 '[', mode 1 ']'); 0x08 stop.
//  All other bytes are NOPs: pc+1.
//  States: IDLE, FETCH, EXEC, IO_IN, IO_OUT, SCAN_F, SCAN_C, HALT.
//  IDLE --start--> FETCH. FETCH: imem_addr<=pc -> EXEC (byte valid). Simple ops take 2 cycles.
//  EXEC ptr: dptr +/-1 (wraps), pc+1 -> FETCH. EXEC data: dmem_we=1, wdata=rdata +/-1 mod 256.
//  EXEC in: -> IO_IN, hold in_ready=1; on in_valid write in_data (dmem_we pulse), pc+1 -> FETCH.
//  EXEC out: -> IO_OUT, hold out_valid=1; on out_ready pc+1 -> FETCH. data/dptr stable while held.
//  '[' with cell==0: depth=1, dir=fwd, pc+1 -> SCAN_F; else pc+1 -> FETCH.
//  ']' with cell!=0: depth=1, dir=bwd, pc-1 -> SCAN_F; else pc+1 -> FETCH.
//  SCAN_F presents pc; SCAN_C inspects the byte. fwd: '[' depth+1, ']' depth-1.
//  bwd: ']' depth+1, '[' depth-1. Depth reaching 0: pc = matched address + 1 -> FETCH.
//  Otherwise step pc in dir -> SCAN_F. No data access during a scan.
//  Scan stepping past pc=2**PC_W-1 (fwd) or below 0 (bwd), or depth+1 overflowing:
//  error=1 -> HALT.
//  stop: halted=1 -> HALT. HALT is terminal: start ignored, all strobes 0.
//  start outside IDLE, in_valid outside IO_IN, and out_ready outside IO_OUT are all ignored.
//  PC increments past max during normal execution wrap to 0 (not an error).
// STRUCTURE
//  bfx_pkg: state enum, op-class localparams (OP_PTR, OP_DATA, OP_IO, OP_BR), STOP_BYTE=8'h08.
//  Sub-module: existing `decode` instantiated on imem_rdata for class strobes; bracket scan
//  stays inline (small FSM plus counter).
// TESTING
//  Reset, start, program {0x02,0x02,0x05,0x08}: out_data=2 on the first out handshake; halted=1; error=0.
//  out_ready held low 20 cycles: out_valid and out_data stay stable; one transfer only.
//  Program {0x04,0x03,0x05,0x08} with in_data=0x00: '-' writes 0xFF; output 0xFF.
//  Loop {0x02,0x02,0x02,0x06,0x03,0x05,0x07,0x08}: outputs 2,1,0; halted.
//  Skip {0x06,0x02,0x06,0x07,0x07,0x05,0x08} (cell=0): output 0; no dmem_we seen.
//  Lone 0x06 with cell=0, and '<' at dptr=0 -> dptr=0xFF; rst_n low mid-IO_IN -> all outputs 0.

Source files
------------

// File: rtl/bfx_pkg.sv
// Shared types and opcode constants for the bfX sequencer.
// The op class is taken from instruction bits [3:1]; bit [0] selects the mode.
package bfx_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_EXEC,
    S_IO_IN,
    S_IO_OUT,
    S_SCAN_F,
    S_SCAN_C,
    S_HALT
  } state_t;

  localparam logic [2:0] OP_PTR  = 3'b000;
  localparam logic [2:0] OP_DATA = 3'b001;
  localparam logic [2:0] OP_IO   = 3'b010;
  localparam logic [2:0] OP_BR   = 3'b011;

  localparam logic [7:0] STOP_BYTE = 8'h08;

endpackage

// File: rtl/decode.sv
// Instruction classifier for bfX: turns one instruction byte into class strobes.
// Only bytes with a zero upper nibble carry a class; every other byte is a NOP.
module decode
  import bfx_pkg::*;
(
  input  logic [7:0] ix,
  output logic       is_ptr,
  output logic       is_data,
  output logic       is_io,
  output logic       is_br,
  output logic       is_stop,
  output logic       mode
);

  logic low_nibble_only;

  assign low_nibble_only = (ix[7:4] == 4'h0);
  assign is_ptr  = low_nibble_only && (ix[3:1] == OP_PTR);
  assign is_data = low_nibble_only && (ix[3:1] == OP_DATA);
  assign is_io   = low_nibble_only && (ix[3:1] == OP_IO);
  assign is_br   = low_nibble_only && (ix[3:1] == OP_BR);
  assign is_stop = (ix == STOP_BYTE);
  assign mode    = ix[0];

endmodule

// File: rtl/bfx_control.sv
// bfX sequencer: fetches, classifies and executes one instruction at a time,
// owning the PC, data pointer and bracket-depth counter.
module bfx_control
  import bfx_pkg::*;
#(
  parameter int PC_W    = 10,
  parameter int DPTR_W  = 8,
  parameter int DEPTH_W = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic [PC_W-1:0]   imem_addr,
  input  logic [7:0]        imem_rdata,
  output logic [DPTR_W-1:0] dptr,
  input  logic [7:0]        dmem_rdata,
  output logic              dmem_we,
  output logic [7:0]        dmem_wdata,
  output logic              in_ready,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [7:0]        out_data,
  output logic              busy,
  output logic              halted,
  output logic              error
);

  localparam logic [PC_W-1:0]    PC_ONE    = 1;
  localparam logic [PC_W-1:0]    PC_MAX    = '1;
  localparam logic [DPTR_W-1:0]  DPTR_ONE  = 1;
  localparam logic [DEPTH_W-1:0] DEPTH_ONE = 1;
  localparam logic [DEPTH_W-1:0] DEPTH_MAX = '1;

  state_t             state, state_n;
  logic [PC_W-1:0]    pc, pc_n;
  logic [DPTR_W-1:0]  dptr_n;
  logic [DEPTH_W-1:0] depth, depth_n;
  logic               dir, dir_n;
  logic               halted_n, error_n;

  logic is_ptr, is_data, is_io, is_br, is_stop, mode;
  logic cell_zero, scan_inc, scan_dec, scan_step;

  decode u_decode (
    .ix      (imem_rdata),
    .is_ptr  (is_ptr),
    .is_data (is_data),
    .is_io   (is_io),
    .is_br   (is_br),
    .is_stop (is_stop),
    .mode    (mode)
  );

  // The PC register drives imem directly, so the sync ROM returns the byte one cycle later.
  assign imem_addr = pc;
  assign cell_zero = (dmem_rdata == 8'h00);
  assign out_data  = out_valid ? dmem_rdata : 8'h00;
  assign busy      = (state != S_IDLE) && (state != S_HALT);

  // During a scan, a bracket matching the scan direction's opener nests deeper (dir 0 = forward).
  assign scan_inc = is_br && (mode == dir);
  assign scan_dec = is_br && (mode != dir);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      pc     <= '0;
      dptr   <= '0;
      depth  <= '0;
      dir    <= 1'b0;
      halted <= 1'b0;
      error  <= 1'b0;
    end else begin
      state  <= state_n;
      pc     <= pc_n;
      dptr   <= dptr_n;
      depth  <= depth_n;
      dir    <= dir_n;
      halted <= halted_n;
      error  <= error_n;
    end
  end

  always_comb begin
    state_n    = state;
    pc_n       = pc;
    dptr_n     = dptr;
    depth_n    = depth;
    dir_n      = dir;
    halted_n   = halted;
    error_n    = error;
    dmem_we    = 1'b0;
    dmem_wdata = 8'h00;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    scan_step  = 1'b0;

    case (state)
      S_IDLE: begin
        if (start) begin
          pc_n    = '0;
          state_n = S_FETCH;
        end
      end
      S_FETCH: state_n = S_EXEC;
      S_EXEC: begin
        state_n = S_FETCH;
        pc_n    = pc + PC_ONE;
        if (is_stop) begin
          pc_n     = pc;
          halted_n = 1'b1;
          state_n  = S_HALT;
        end else if (is_ptr) begin
          dptr_n = mode ? dptr - DPTR_ONE : dptr + DPTR_ONE;
        end else if (is_data) begin
          dmem_we    = 1'b1;
          dmem_wdata = mode ? dmem_rdata - 8'd1 : dmem_rdata + 8'd1;
        end else if (is_io) begin
          pc_n    = pc;
          state_n = mode ? S_IO_OUT : S_IO_IN;
        end else if (is_br && !mode && cell_zero) begin
          depth_n = DEPTH_ONE;
          dir_n   = 1'b0;
          state_n = S_SCAN_F;
          if (pc == PC_MAX) begin
            pc_n    = pc;
            error_n = 1'b1;
            state_n = S_HALT;
          end
        end else if (is_br && mode && !cell_zero) begin
          depth_n = DEPTH_ONE;
          dir_n   = 1'b1;
          pc_n    = pc - PC_ONE;
          state_n = S_SCAN_F;
          if (pc == '0) begin
            pc_n    = pc;
            error_n = 1'b1;
            state_n = S_HALT;
          end
        end
      end
      S_IO_IN: begin
        in_ready = 1'b1;
        if (in_valid) begin
          dmem_we    = 1'b1;
          dmem_wdata = in_data;
          pc_n       = pc + PC_ONE;
          state_n    = S_FETCH;
        end
      end
      S_IO_OUT: begin
        out_valid = 1'b1;
        if (out_ready) begin
          pc_n    = pc + PC_ONE;
          state_n = S_FETCH;
        end
      end
      S_SCAN_F: state_n = S_SCAN_C;
      // Matching bracket found: resume just after it regardless of scan direction.
      S_SCAN_C: begin
        if (scan_inc) begin
          if (depth == DEPTH_MAX) begin
            error_n = 1'b1;
            state_n = S_HALT;
          end else begin
            depth_n   = depth + DEPTH_ONE;
            scan_step = 1'b1;
          end
        end else if (scan_dec && depth == DEPTH_ONE) begin
          depth_n = '0;
          pc_n    = pc + PC_ONE;
          state_n = S_FETCH;
        end else begin
          if (scan_dec) depth_n = depth - DEPTH_ONE;
          scan_step = 1'b1;
        end
        if (scan_step) begin
          if ((!dir && pc == PC_MAX) || (dir && pc == '0)) begin
            error_n = 1'b1;
            state_n = S_HALT;
          end else begin
            pc_n    = dir ? pc - PC_ONE : pc + PC_ONE;
            state_n = S_SCAN_F;
          end
        end
      end
      S_HALT: state_n = S_HALT;
      default: state_n = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_bfx_control.sv
// Scoreboard bench for bfx_control: directed programs push expected output bytes,
// and a monitor pops and compares them on every out handshake.
module tb_bfx_control;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [9:0] imem_addr;
  logic [7:0] imem_rdata = 8'h00;
  logic [7:0] dptr;
  logic [7:0] dmem_rdata;
  logic       dmem_we;
  logic [7:0] dmem_wdata;
  logic       in_ready;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] out_data;
  logic       busy;
  logic       halted;
  logic       error;

  logic [7:0] imem [1024];
  logic [7:0] dmem [256];
  logic [7:0] dmem_init [256];
  logic [7:0] exp_q [$];
  logic [7:0] prog [$];
  int checks = 0;
  int errors = 0;
  int we_count = 0;

  always #5 clk = ~clk;

  bfx_control dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .dptr       (dptr),
    .dmem_rdata (dmem_rdata),
    .dmem_we    (dmem_we),
    .dmem_wdata (dmem_wdata),
    .in_ready   (in_ready),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .busy       (busy),
    .halted     (halted),
    .error      (error)
  );

  always @(posedge clk) imem_rdata <= imem[imem_addr];

  assign dmem_rdata = dmem[dptr];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 256; i++) dmem[i] <= dmem_init[i];
    end else if (dmem_we) begin
      dmem[dptr] <= dmem_wdata;
    end
  end

  // Handshakes complete on the following rising edge; compare at the falling edge before it.
  always @(negedge clk) begin
    if (rst_n) begin
      if (dmem_we) we_count++;
      if (out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("[TB] FAIL out_unexpected: got 0x%02h, required no transfer", out_data);
        end else begin
          logic [7:0] exp_byte;
          exp_byte = exp_q.pop_front();
          if (out_data !== exp_byte) begin
            errors++;
            $display("[TB] FAIL out_data: got 0x%02h, required 0x%02h", out_data, exp_byte);
          end
        end
      end
    end
  end

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic apply_stimulus(input logic [7:0] p [$]);
    for (int i = 0; i < 1024; i++) imem[i] = 8'h08;
    for (int i = 0; i < p.size(); i++) imem[i] = p[i];
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    we_count = 0;
    @(posedge clk);
    #1;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int n = 0;
    while (!(halted || error) && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    check_output({name, "_timeout"}, (n >= budget) ? 1 : 0, 0);
  endtask

  task automatic wait_signal_in_ready(input int budget);
    int n = 0;
    while (!in_ready && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    check_output("in_ready_timeout", (n >= budget) ? 1 : 0, 0);
  endtask

  initial begin
    int bad;
    int n;
    for (int i = 0; i < 256; i++) dmem_init[i] = 8'h00;
    for (int i = 0; i < 1024; i++) imem[i] = 8'h08;

    #1;
    check_output("reset_flags", {26'd0, busy, halted, error, in_ready, out_valid, dmem_we}, 0);
    check_output("reset_dptr", dptr, 0);
    check_output("reset_imem_addr", imem_addr, 0);

    // Output held off for 20 cycles: byte must stay put and transfer exactly once.
    exp_q.push_back(8'h02);
    prog = '{8'h02, 8'h02, 8'h05, 8'h08};
    apply_stimulus(prog);
    n = 0;
    while (!out_valid && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    check_output("out_valid_timeout", (n >= 100) ? 1 : 0, 0);
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (!(out_valid === 1'b1 && out_data === 8'h02)) bad++;
    end
    check_output("stall_stable", bad, 0);
    out_ready = 1'b1;
    wait_done("prog1", 200);
    check_output("prog1_halted", {halted, error, busy}, 3'b100);
    check_output("prog1_drained", exp_q.size(), 0);
    start = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    start = 1'b0;
    check_output("halt_ignores_start", {busy, halted}, 2'b01);

    in_valid = 1'b1;
    in_data = 8'h00;
    exp_q.push_back(8'hFF);
    prog = '{8'h04, 8'h03, 8'h05, 8'h08};
    apply_stimulus(prog);
    wait_done("prog2", 200);
    in_valid = 1'b0;
    check_output("prog2_cell", dmem[0], 8'hFF);
    check_output("prog2_drained", exp_q.size(), 0);

    exp_q.push_back(8'h02);
    exp_q.push_back(8'h01);
    exp_q.push_back(8'h00);
    prog = '{8'h02, 8'h02, 8'h02, 8'h06, 8'h03, 8'h05, 8'h07, 8'h08};
    apply_stimulus(prog);
    wait_done("loop", 500);
    check_output("loop_halted", {halted, error}, 2'b10);
    check_output("loop_drained", exp_q.size(), 0);

    exp_q.push_back(8'h00);
    prog = '{8'h06, 8'h02, 8'h06, 8'h07, 8'h07, 8'h05, 8'h08};
    apply_stimulus(prog);
    wait_done("skip", 300);
    check_output("skip_no_write", we_count, 0);
    check_output("skip_drained", exp_q.size(), 0);
    check_output("skip_halted", {halted, error}, 2'b10);

    prog = '{8'h06};
    apply_stimulus(prog);
    wait_done("lone_open", 5000);
    check_output("lone_open_error", {halted, error, busy}, 3'b010);

    dmem_init[255] = 8'h5A;
    exp_q.push_back(8'h5A);
    prog = '{8'h01, 8'h05, 8'h08};
    apply_stimulus(prog);
    wait_done("ptr_wrap", 200);
    dmem_init[255] = 8'h00;
    check_output("ptr_wrap_dptr", dptr, 8'hFF);
    check_output("ptr_wrap_drained", exp_q.size(), 0);

    // Reset while the sequencer waits for input must drop everything at once.
    prog = '{8'h04};
    apply_stimulus(prog);
    wait_signal_in_ready(100);
    rst_n = 1'b0;
    #1;
    check_output("abort_flags", {26'd0, busy, halted, error, in_ready, out_valid, dmem_we}, 0);
    check_output("abort_ptrs", {dptr, imem_addr}, 0);
    check_output("abort_data", {out_data, dmem_wdata}, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
